ternary_neuron_acc: RTL and testbench



---
 rtl/ternary_neuron_acc.sv | 113 +++++++++++
 tb/tb_ternary_neuron_acc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_neuron_acc.sv
// ternary_neuron_acc: accumulates (pos - neg) popcount differences over
// N_BEATS input beats, thresholds the signed sum and presents a ternary
// (or binary) activation under a valid/ready handshake.
// Optional feature macro: TNN_ACC_TERNARY_EN.
// - When it is defined, the block produces a three-level activation (+1 / 0 / -1).
// - When it is undefined, the block produces a binary activation (+1 / -1).
module ternary_neuron_acc #(
  parameter int N_BEATS = 4,
  parameter int CNT_W   = 3,
  parameter int ACC_W   = $clog2(7*N_BEATS+1)+1,
  parameter int TH_POS  = 2,
  parameter int TH_NEG  = -2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CNT_W-1:0]        in_pos,
  input  logic [CNT_W-1:0]        in_neg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_sum
);

  localparam int BC_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(N_BEATS-1);
  localparam logic signed [ACC_W-1:0] TH_POS_X = ACC_W'(TH_POS);
`ifdef TNN_ACC_TERNARY_EN
  localparam logic signed [ACC_W-1:0] TH_NEG_X = ACC_W'(TH_NEG);
`endif

  // The negative threshold must never sit above the positive one.
  if (TH_NEG > TH_POS) begin : g_th_check
    $error("ternary_neuron_acc: TH_NEG must not exceed TH_POS");
  end

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc_p0;
  logic [BC_W-1:0]         beat_cnt_p0;
  logic signed [ACC_W-1:0] sum_p1;
  logic [1:0]              act_p1;
  logic signed [ACC_W-1:0] delta;
  logic signed [ACC_W-1:0] sum_nxt;
  logic                    accept;
  logic                    last_beat;

  // Threshold the final sum into the activation code.
  function automatic logic [1:0] activate(input logic signed [ACC_W-1:0] s);
`ifdef TNN_ACC_TERNARY_EN
    if (s >= TH_POS_X)      return 2'b01;
    else if (s <= TH_NEG_X) return 2'b11;
    else                    return 2'b00;
`else
    if (s >= TH_POS_X) return 2'b01;
    else               return 2'b11;
`endif
  endfunction

  assign in_ready  = (state != OUT);
  assign out_valid = (state == OUT);
  assign out_sum   = sum_p1;
  assign out_act   = act_p1;

  // Beat acceptance, popcount difference and next FSM state.
  always_comb begin
    state_nxt = state;
    accept    = in_valid && (state != OUT);
    last_beat = (beat_cnt_p0 == LAST_BEAT);
    // Popcounts are zero-extended; out-of-contract values 6..7 pass through unchanged.
    delta     = $signed(ACC_W'(in_pos)) - $signed(ACC_W'(in_neg));
    sum_nxt   = acc_p0 + delta;
    case (state)
      IDLE, ACC: begin
        if (accept) state_nxt = last_beat ? OUT : ACC;
      end
      OUT: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0 -> p1: accumulate beats; the last beat closes the sum into the
  // held result registers and rearms the accumulator for the next neuron.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0      <= '0;
      beat_cnt_p0 <= '0;
      sum_p1      <= '0;
      act_p1      <= 2'b00;
    end else if (accept) begin
      if (last_beat) begin
        acc_p0      <= '0;
        beat_cnt_p0 <= '0;
        sum_p1      <= sum_nxt;
        act_p1      <= activate(sum_nxt);
      end else begin
        acc_p0      <= sum_nxt;
        beat_cnt_p0 <= beat_cnt_p0 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Testbench for ternary_neuron_acc: directed plan cases plus randomized
// neurons, checked through an expected-result queue and a separate monitor.
module tb_ternary_neuron_acc;

  localparam int N_BEATS = 4;
  localparam int CNT_W   = 3;
  localparam int ACC_W   = $clog2(7*N_BEATS+1)+1;
  localparam int TH_POS  = 2;
  localparam int TH_NEG  = -2;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [1:0]       act;
  } result_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [CNT_W-1:0]        in_pos = '0;
  logic [CNT_W-1:0]        in_neg = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [1:0]              out_act;
  logic signed [ACC_W-1:0] out_sum;

  int      n_tests = 0;
  int      n_fail  = 0;
  result_t exp_q[$];
  int      beat_vals[$];
  bit      rand_ready = 1'b0;

  ternary_neuron_acc #(
    .N_BEATS(N_BEATS), .CNT_W(CNT_W), .ACC_W(ACC_W), .TH_POS(TH_POS), .TH_NEG(TH_NEG)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .out_valid(out_valid), .out_ready(out_ready),
    .out_act(out_act), .out_sum(out_sum)
  );

  always #5 clk = ~clk;

  // Reference activation, straight from the threshold rules.
  function automatic logic [1:0] ref_act(input int s);
`ifdef TNN_ACC_TERNARY_EN
    if (s >= TH_POS) return 2'b01;
    if (s <= TH_NEG) return 2'b11;
    return 2'b00;
`else
    if (s >= TH_POS) return 2'b01;
    return 2'b11;
`endif
  endfunction

  task automatic check(input string name, input int actual, input int required);
    n_tests++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // Model: the neuron result is the plain sum of the per-beat differences.
  task automatic model_accept(input int p, input int n);
    int s;
    result_t r;
    beat_vals.push_back(p - n);
    if (beat_vals.size() == N_BEATS) begin
      s = 0;
      foreach (beat_vals[i]) s += beat_vals[i];
      r.sum = ACC_W'(s);
      r.act = ref_act(s);
      exp_q.push_back(r);
      beat_vals.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic beat(input int p, input int n);
    bit rdy;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_pos   = CNT_W'(p);
    in_neg   = CNT_W'(n);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      if (rdy) begin
        done = 1'b1;
        model_accept(p, n);
      end
    end
    in_valid = 1'b0;
    if (!done) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) tick();
  endtask

  // Monitor: pop an expectation when a result appears, then require it to hold.
  task automatic monitor();
    bit      presenting;
    result_t held;
    result_t e;
    presenting = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        presenting = 1'b0;
      end else if (!presenting) begin
        presenting = 1'b1;
        held.sum = out_sum;
        held.act = out_act;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_sum", int'(out_sum), int'($signed(e.sum)));
          check("out_act", int'(out_act), int'(e.act));
        end
      end else begin
        check("hold_sum", int'(out_sum), int'($signed(held.sum)));
        check("hold_act", int'(out_act), int'(held.act));
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_act", int'(out_act), 0);
    check("rst_out_sum", int'(out_sum), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    tick();

    // Back-to-back beats, latency and in_ready drop for exactly one cycle
    out_ready = 1'b1;
    for (int i = 0; i < N_BEATS; i++) beat(5, 0);
    check("lat_out_valid", int'(out_valid), 1);
    check("lat_in_ready", int'(in_ready), 0);
    tick();
    check("post_out_valid", int'(out_valid), 0);
    check("post_in_ready", int'(in_ready), 1);

    // Zero sum
    for (int i = 0; i < N_BEATS; i++) beat(1, 1);
    tick();

    // Gapped beats and threshold edges
    beat(0, 1); idle(2); beat(1, 0); idle(2); beat(0, 1); idle(2); beat(0, 0);
    tick();
    beat(0, 2); beat(0, 0); beat(0, 0); beat(0, 0);
    tick();
    beat(2, 0); beat(0, 0); beat(0, 0); beat(0, 0);
    tick();

    // Consumer stall with in_valid asserted during OUT
    out_ready = 1'b0;
    for (int i = 0; i < N_BEATS; i++) beat(0, 5);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_pos   = 3'd5;
      in_neg   = 3'd0;
      @(negedge clk);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_out_valid", int'(out_valid), 0);

    // Reset mid-accumulation discards the partial sum
    beat(5, 0); beat(5, 0);
    beat_vals.delete();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_sum", int'(out_sum), 0);
    check("midrst_out_act", int'(out_act), 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < N_BEATS; i++) beat(1, 0);
    tick();

    // Randomized neurons with random gaps and consumer stalls
    rand_ready = 1'b1;
    for (int nrn = 0; nrn < 40; nrn++) begin
      for (int b = 0; b < N_BEATS; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) beat($urandom_range(0, 7), $urandom_range(0, 7));
        else                           beat($urandom_range(0, 5), $urandom_range(0, 5));
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    // Drain
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    repeat (2) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
